// File: rtl/lmc1992_rx.sv
// LMC1992 volume/tone controller: MicroWire command receiver and
// attenuating two-stage audio datapath for 8-bit DMA sound samples.
module lmc1992_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] DEV_ADDR    = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mw_clk,
    input  logic       mw_data,
    input  logic       mw_en,
    input  logic       sample_en,
    input  logic [7:0] audio_l_in,
    input  logic [7:0] audio_r_in,
    output logic [7:0] audio_l_out,
    output logic [7:0] audio_r_out,
    output logic       out_valid,
    output logic [5:0] vol_master,
    output logic [4:0] vol_left,
    output logic [4:0] vol_right,
    output logic [3:0] bass,
    output logic [3:0] treble,
    output logic [1:0] mix
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE} state_t;

    logic [SYNC_STAGES-1:0] r_sck, r_sdt, r_sen;
    logic                   r_sck_d, r_sen_d;
    logic                   w_ck, w_dt, w_en;
    logic                   w_ck_rise, w_en_rise, w_en_fall;

    state_t      r_state, w_next;
    logic [10:0] r_sh;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic [2:0]  w_func;
    logic [5:0]  w_d;

    assign w_ck      = r_sck[SYNC_STAGES-1];
    assign w_dt      = r_sdt[SYNC_STAGES-1];
    assign w_en      = r_sen[SYNC_STAGES-1];
    assign w_ck_rise = w_ck & ~r_sck_d;
    assign w_en_rise = w_en & ~r_sen_d;
    assign w_en_fall = ~w_en & r_sen_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck   <= '0;
            r_sdt   <= '0;
            r_sen   <= '0;
            r_sck_d <= 1'b0;
            r_sen_d <= 1'b0;
        end else begin
            r_sck   <= {r_sck[SYNC_STAGES-2:0], mw_clk};
            r_sdt   <= {r_sdt[SYNC_STAGES-2:0], mw_data};
            r_sen   <= {r_sen[SYNC_STAGES-2:0], mw_en};
            r_sck_d <= w_ck;
            r_sen_d <= w_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_en_rise) w_next = S_SHIFT;
            S_SHIFT:  if (w_en_fall) w_next = S_DECODE;
            S_DECODE: w_next = w_en_rise ? S_SHIFT : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // A bit clocked in alongside the mw_en fall still lands before decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (r_state != S_SHIFT && w_next == S_SHIFT) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT && w_ck_rise) begin
            r_sh  <= {r_sh[9:0], w_dt};
            r_cnt <= (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
        end
    end

    assign w_func   = r_sh[8:6];
    assign w_d      = r_sh[5:0];
    assign w_accept = (r_state == S_DECODE) && (r_cnt >= 4'd11)
                      && (r_sh[10:9] == DEV_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vol_master <= 6'd40;
            vol_left   <= 5'd20;
            vol_right  <= 5'd20;
            bass       <= 4'd6;
            treble     <= 4'd6;
            mix        <= 2'b01;
        end else if (w_accept) begin
            case (w_func)
                3'b000: if (w_d[1:0] != 2'b11) mix <= w_d[1:0];
                3'b001: bass <= (w_d[3:0] > 4'd12) ? 4'd12 : w_d[3:0];
                3'b010: treble <= (w_d[3:0] > 4'd12) ? 4'd12 : w_d[3:0];
                3'b011: vol_master <= (w_d > 6'd40) ? 6'd40 : w_d;
                3'b100: vol_right <= (w_d[4:0] > 5'd20) ? 5'd20 : w_d[4:0];
                3'b101: vol_left <= (w_d[4:0] > 5'd20) ? 5'd20 : w_d[4:0];
                default: ;
            endcase
        end
    end

    function automatic logic [8:0] gain_of(input logic [6:0] n);
        case (n % 7'd3)
            7'd0:    gain_of = 9'd256;
            7'd1:    gain_of = 9'd203;
            default: gain_of = 9'd161;
        endcase
    endfunction

    logic [6:0] w_n_l, w_n_r;
    logic [8:0] r_g_l, r_g_r;
    logic [6:0] r_k_l, r_k_r;

    assign w_n_l = (7'd40 - {1'b0, vol_master}) + (7'd20 - {2'b0, vol_left});
    assign w_n_r = (7'd40 - {1'b0, vol_master}) + (7'd20 - {2'b0, vol_right});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_g_l <= 9'd256;
            r_g_r <= 9'd256;
            r_k_l <= '0;
            r_k_r <= '0;
        end else begin
            r_g_l <= gain_of(w_n_l);
            r_g_r <= gain_of(w_n_r);
            r_k_l <= w_n_l / 7'd3;
            r_k_r <= w_n_r / 7'd3;
        end
    end

    // Flipping the MSB turns offset-128 into two's complement and back.
    logic signed [17:0] w_sx_l, w_sx_r, w_gx_l, w_gx_r;
    logic signed [17:0] r_p_l, r_p_r, w_o_l, w_o_r;
    logic [6:0]         r_k1_l, r_k1_r;
    logic               r_v1;

    assign w_sx_l = {{11{~audio_l_in[7]}}, audio_l_in[6:0]};
    assign w_sx_r = {{11{~audio_r_in[7]}}, audio_r_in[6:0]};
    assign w_gx_l = {9'b0, r_g_l};
    assign w_gx_r = {9'b0, r_g_r};
    assign w_o_l  = (r_p_l >>> 8) >>> r_k1_l;
    assign w_o_r  = (r_p_r >>> 8) >>> r_k1_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1        <= 1'b0;
            r_p_l       <= '0;
            r_p_r       <= '0;
            r_k1_l      <= '0;
            r_k1_r      <= '0;
            out_valid   <= 1'b0;
            audio_l_out <= 8'h80;
            audio_r_out <= 8'h80;
        end else begin
            r_v1      <= sample_en;
            out_valid <= r_v1;
            if (sample_en) begin
                r_p_l  <= w_sx_l * w_gx_l;
                r_p_r  <= w_sx_r * w_gx_r;
                r_k1_l <= r_k_l;
                r_k1_r <= r_k_r;
            end
            if (r_v1) begin
                audio_l_out <= 8'(w_o_l) ^ 8'h80;
                audio_r_out <= 8'(w_o_r) ^ 8'h80;
            end
        end
    end

endmodule

// File: tb/tb_lmc1992_rx.sv
// Bench for lmc1992_rx: MicroWire commands and audio samples checked
// against an arithmetic model of the controller registers and gain law.
module tb_lmc1992_rx;

    logic       clk = 1'b0;
    logic       reset, mw_clk, mw_data, mw_en, sample_en;
    logic [7:0] audio_l_in, audio_r_in, audio_l_out, audio_r_out;
    logic       out_valid;
    logic [5:0] vol_master;
    logic [4:0] vol_left, vol_right;
    logic [3:0] bass, treble;
    logic [1:0] mix;

    lmc1992_rx dut (
        .clk(clk), .reset(reset),
        .mw_clk(mw_clk), .mw_data(mw_data), .mw_en(mw_en),
        .sample_en(sample_en),
        .audio_l_in(audio_l_in), .audio_r_in(audio_r_in),
        .audio_l_out(audio_l_out), .audio_r_out(audio_r_out),
        .out_valid(out_valid),
        .vol_master(vol_master), .vol_left(vol_left), .vol_right(vol_right),
        .bass(bass), .treble(treble), .mix(mix)
    );

    always #62 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int m_master, m_left, m_right, m_bass, m_treble, m_mix;

    function automatic void m_reset();
        m_master = 40; m_left = 20; m_right = 20;
        m_bass = 6; m_treble = 6; m_mix = 1;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void m_apply(input int c);
        int d, f;
        d = c & 63;
        f = (c >> 6) & 7;
        if (((c >> 9) & 3) != 2) return;
        case (f)
            0: if ((d & 3) != 3) m_mix = d & 3;
            1: m_bass = imin(d & 15, 12);
            2: m_treble = imin(d & 15, 12);
            3: m_master = imin(d, 40);
            4: m_right = imin(d & 31, 20);
            5: m_left = imin(d & 31, 20);
            default: ;
        endcase
    endfunction

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int m_out(input int x, input int side);
        int gt[3];
        int n, v;
        gt = '{256, 203, 161};
        n = (40 - m_master) + (20 - side);
        v = fdiv((x - 128) * gt[n % 3], 256);
        v = fdiv(v, 1 << (n / 3));
        return (v + 128) & 255;
    endfunction

    typedef struct {
        int l;
        int r;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                m_e = q.pop_front();
                chk("latency", cyc, m_e.due);
                chk("out_l", int'(audio_l_out), m_e.l);
                chk("out_r", int'(audio_r_out), m_e.r);
            end
        end
    end

    task automatic burst(input int n, input int l0, input int r0);
        exp_t e;
        int l, r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            l = (i == 0 && l0 >= 0) ? l0 : int'($urandom_range(0, 255));
            r = (i == 0 && r0 >= 0) ? r0 : int'($urandom_range(0, 255));
            sample_en  = 1'b1;
            audio_l_in = 8'(l);
            audio_r_in = 8'(r);
            e.l   = m_out(l, m_left);
            e.r   = m_out(r, m_right);
            e.due = cyc + 2;
            q.push_back(e);
        end
        @(negedge clk);
        sample_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("valid_idle", int'(out_valid), 0);
        chk("drained", q.size(), 0);
    endtask

    task automatic mw_bits(input int val, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mw_data = val[i];
            repeat (3) @(negedge clk);
            mw_clk = 1'b1;
            repeat (3) @(negedge clk);
            mw_clk = 1'b0;
        end
    endtask

    task automatic mw_send(input int val, input int nb);
        @(negedge clk);
        mw_en = 1'b1;
        repeat (4) @(negedge clk);
        mw_bits(val, nb - 1, 0);
        repeat (3) @(negedge clk);
        mw_en   = 1'b0;
        mw_data = 1'b0;
        repeat (10) @(negedge clk);
        if (nb >= 11) m_apply(val & 'h7FF);
    endtask

    task automatic chk_regs();
        chk("vol_master", int'(vol_master), m_master);
        chk("vol_left", int'(vol_left), m_left);
        chk("vol_right", int'(vol_right), m_right);
        chk("bass", int'(bass), m_bass);
        chk("treble", int'(treble), m_treble);
        chk("mix", int'(mix), m_mix);
    endtask

    initial begin
        int cmd, nb;
        reset = 1'b1;
        mw_clk = 1'b0; mw_data = 1'b0; mw_en = 1'b0;
        sample_en = 1'b0; audio_l_in = 8'h00; audio_r_in = 8'h00;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_regs();
        chk("rst_out_l", int'(audio_l_out), 'h80);
        chk("rst_out_r", int'(audio_r_out), 'h80);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_master_const", int'(vol_master), 40);

        burst(1, 'hC0, 'hC0);
        mw_send('h4E5, 11);
        chk("master_37", int'(vol_master), 37);
        burst(1, 'hC0, 'hC0);
        mw_send('h4E7, 11);
        burst(1, 'hC0, 'hC0);
        mw_send('h4FF, 11);
        chk("master_clamp", int'(vol_master), 40);
        mw_send('h54F, 11);
        chk("left_15", int'(vol_left), 15);
        burst(1, 'h40, 'h40);
        chk_regs();

        mw_send('h2E8, 11);
        chk_regs();
        mw_send('h4E5, 10);
        chk_regs();
        mw_send('hCE5, 12);
        chk("master_12b", int'(vol_master), 37);
        chk_regs();
        burst(3, -1, -1);

        @(negedge clk);
        mw_en = 1'b1;
        repeat (4) @(negedge clk);
        mw_bits('h4E5, 10, 5);
        reset = 1'b1;
        mw_en = 1'b0;
        mw_clk = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (5) @(negedge clk);
        chk_regs();
        mw_send('h440, 11);
        chk("bass_0", int'(bass), 0);

        for (int it = 0; it < 24; it++) begin
            cmd = int'($urandom_range(0, 'h1FF));
            cmd |= (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 2) << 9;
            cmd |= int'($urandom_range(0, 3)) << 11;
            nb = int'($urandom_range(10, 13));
            mw_send(cmd, nb);
            chk_regs();
            burst(int'($urandom_range(1, 4)), -1, -1);
        end

        chk("pending", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
